// File: rtl/arp_send_if.sv
`default_nettype none
// ============================================================================
// Module   : arp_send_if
// Brief    : Start/field inputs, CRC feedback and MII TX outputs of arp_send.
// Revision : 1.0
// ============================================================================
interface arp_send_if;
  logic        send_en;
  logic        arp_type;
  logic [47:0] des_mac;
  logic [31:0] des_ip;
  logic [31:0] crc_data;
  logic [3:0]  crc_next;
  logic        eth_tx_en;
  logic [3:0]  eth_tx_data;
  logic        crc_en;
  logic        crc_clr;
  logic        send_end;

  modport master (
    output send_en, arp_type, des_mac, des_ip, crc_data, crc_next,
    input  eth_tx_en, eth_tx_data, crc_en, crc_clr, send_end
  );

  modport slave (
    input  send_en, arp_type, des_mac, des_ip, crc_data, crc_next,
    output eth_tx_en, eth_tx_data, crc_en, crc_clr, send_end
  );
endinterface
`default_nettype wire

// File: rtl/arp_send.sv
`default_nettype none
// ============================================================================
// Module   : arp_send
// Brief    : Nibble-wide MII transmitter for ARP request/reply frames.
// Revision : 1.0
// ============================================================================
module arp_send #(
  parameter logic [47:0] BOARD_MAC = 48'h12_34_56_78_9A_BC,
  parameter logic [31:0] BOARD_IP  = {8'd169, 8'd254, 8'd1, 8'd23}
) (
  input wire logic  eth_tx_clk,
  input wire logic  sys_rst_n,
  arp_send_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    ETH_HEAD = 3'd2,
    ARP_DATA = 3'd3,
    CRC      = 3'd4,
    GAP      = 3'd5
  } state_t;

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        arp_type_q;
  logic [47:0] des_mac_q;
  logic [31:0] des_ip_q;
  logic        tx_en_q;
  logic [3:0]  tx_data_q;
  logic        crc_en_q;
  logic        crc_clr_q;
  logic        send_end_q;

  // Byte idx of a MAC / IP, most significant byte first on the wire.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [7:0] idx);
    return mac[40 - 8 * int'(idx) +: 8];
  endfunction

  function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [7:0] idx);
    return ip[24 - 8 * int'(idx) +: 8];
  endfunction

  function automatic logic [7:0] head_byte(input logic [7:0] b, input logic [47:0] dst);
    logic [7:0] r;
    if (b < 8'd6)       r = mac_byte(dst, b);
    else if (b < 8'd12) r = mac_byte(BOARD_MAC, b - 8'd6);
    else if (b == 8'd12) r = 8'h08;
    else                r = 8'h06;
    return r;
  endfunction

  // ARP body followed by zero padding up to the 60-byte minimum frame.
  function automatic logic [7:0] arp_byte(input logic [7:0] b, input logic typ,
                                          input logic [47:0] tmac, input logic [31:0] tip);
    logic [7:0] r;
    case (b)
      8'd1:    r = 8'h01;
      8'd2:    r = 8'h08;
      8'd4:    r = 8'h06;
      8'd5:    r = 8'h04;
      8'd7:    r = typ ? 8'h02 : 8'h01;
      default: begin
        if (b >= 8'd8 && b <= 8'd13)       r = mac_byte(BOARD_MAC, b - 8'd8);
        else if (b >= 8'd14 && b <= 8'd17) r = ip_byte(BOARD_IP, b - 8'd14);
        else if (b >= 8'd18 && b <= 8'd23) r = typ ? mac_byte(tmac, b - 8'd18) : 8'h00;
        else if (b >= 8'd24 && b <= 8'd27) r = ip_byte(tip, b - 8'd24);
        else                               r = 8'h00;
      end
    endcase
    return r;
  endfunction

  logic [7:0]  cnt_inc;
  logic [7:0]  head_idx;
  logic [7:0]  arp_idx;
  logic [7:0]  head_b;
  logic [7:0]  arp_b;
  logic [47:0] dst_mac;
  logic [3:0]  head_nib;
  logic [3:0]  arp_nib;
  logic [3:0]  fcs_sel;
  logic [3:0]  fcs_nib;
  logic [3:0]  fcs0_nib;

  // Outputs are registered, so lookups address the nibble for the next cycle;
  // the first nibble of a section is fetched while the previous one ends.
  assign cnt_inc  = cnt_q + 8'd1;
  assign head_idx = (state_q == ETH_HEAD) ? cnt_inc : 8'd0;
  assign arp_idx  = (state_q == ARP_DATA) ? cnt_inc : 8'd0;
  assign dst_mac  = arp_type_q ? des_mac_q : 48'hFFFF_FFFF_FFFF;
  assign head_b   = head_byte(head_idx >> 1, dst_mac);
  assign arp_b    = arp_byte(arp_idx >> 1, arp_type_q, des_mac_q, des_ip_q);
  assign head_nib = head_idx[0] ? head_b[7:4] : head_b[3:0];
  assign arp_nib  = arp_idx[0] ? arp_b[7:4] : arp_b[3:0];
  assign fcs_sel  = bus.crc_data[28 - 4 * int'(cnt_inc[2:0]) +: 4];
  assign fcs_nib  = ~{fcs_sel[0], fcs_sel[1], fcs_sel[2], fcs_sel[3]};
  assign fcs0_nib = ~{bus.crc_next[0], bus.crc_next[1], bus.crc_next[2], bus.crc_next[3]};

  always_ff @(posedge eth_tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      arp_type_q <= 1'b0;
      des_mac_q  <= 48'd0;
      des_ip_q   <= 32'd0;
      tx_en_q    <= 1'b0;
      tx_data_q  <= 4'h0;
      crc_en_q   <= 1'b0;
      crc_clr_q  <= 1'b0;
      send_end_q <= 1'b0;
    end else begin
      crc_clr_q  <= 1'b0;
      send_end_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.send_en) begin
            state_q    <= PREAMBLE;
            cnt_q      <= 8'd0;
            arp_type_q <= bus.arp_type;
            des_mac_q  <= bus.des_mac;
            des_ip_q   <= bus.des_ip;
            tx_en_q    <= 1'b1;
            tx_data_q  <= 4'h5;
          end
        end
        PREAMBLE: begin
          if (cnt_q == 8'd15) begin
            state_q   <= ETH_HEAD;
            cnt_q     <= 8'd0;
            tx_data_q <= head_nib;
            crc_en_q  <= 1'b1;
          end else begin
            cnt_q     <= cnt_inc;
            tx_data_q <= (cnt_inc == 8'd15) ? 4'hD : 4'h5;
          end
        end
        ETH_HEAD: begin
          if (cnt_q == 8'd27) begin
            state_q   <= ARP_DATA;
            cnt_q     <= 8'd0;
            tx_data_q <= arp_nib;
          end else begin
            cnt_q     <= cnt_inc;
            tx_data_q <= head_nib;
          end
        end
        ARP_DATA: begin
          // The last data nibble is on the wire now, so crc_next already holds it.
          if (cnt_q == 8'd91) begin
            state_q   <= CRC;
            cnt_q     <= 8'd0;
            tx_data_q <= fcs0_nib;
            crc_en_q  <= 1'b0;
          end else begin
            cnt_q     <= cnt_inc;
            tx_data_q <= arp_nib;
          end
        end
        CRC: begin
          if (cnt_q == 8'd7) begin
            state_q    <= GAP;
            cnt_q      <= 8'd0;
            tx_en_q    <= 1'b0;
            tx_data_q  <= 4'h0;
            send_end_q <= 1'b1;
            crc_clr_q  <= 1'b1;
          end else begin
            cnt_q     <= cnt_inc;
            tx_data_q <= fcs_nib;
          end
        end
        GAP: begin
          if (cnt_q == 8'd23) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

  assign bus.eth_tx_en   = tx_en_q;
  assign bus.eth_tx_data = tx_data_q;
  assign bus.crc_en      = crc_en_q;
  assign bus.crc_clr     = crc_clr_q;
  assign bus.send_end    = send_end_q;

endmodule
`default_nettype wire
